pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the MIPS core. It is the generalised replacement for the fixed pc/inst stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- MODE 0: classic 6-bit stall-vector control with bubble insertion.
- MODE 1: valid/ready handshake with a 2-entry skid buffer, for decoupled stages.
- Both modes: synchronous flush and saturating stall/bubble performance counters.

---
 rtl/pipe_stage_reg_pkg.sv | 27 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the parametrised inter-stage pipeline register.
package pipe_stage_reg_pkg;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int unsigned STALL_W_DEFAULT = 6;

    localparam int unsigned MODE_STALL = 0;
    localparam int unsigned MODE_SKID  = 1;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: stall-vector mode with bubble insertion, or a
// valid/ready 2-entry skid buffer. Both modes carry flush and perf counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       STALL_W    = STALL_W_DEFAULT,
    parameter int unsigned       STAGE      = STG_IF,
    parameter int unsigned       MODE       = MODE_STALL,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic hold_inc;
    logic bubble_inc;

    if (MODE == MODE_STALL) begin : g_stall
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              unused_sig;

        // Only stall[STAGE] and stall[STAGE+1] matter here.
        assign unused_sig = out_ready ^ (^stall);

        always_comb begin
            data_d     = data_q;
            valid_d    = valid_q;
            hold_inc   = Disable;
            bubble_inc = Disable;
            if (flush) begin
                data_d  = BUBBLE_VAL;
                valid_d = Disable;
            end else if (stall[STAGE] && !stall[STAGE+1]) begin
                data_d     = BUBBLE_VAL;
                valid_d    = Disable;
                bubble_inc = Enable;
            end else if (!stall[STAGE]) begin
                data_d  = in_data;
                valid_d = in_valid;
            end else begin
                hold_inc = valid_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= BUBBLE_VAL;
                valid_q <= Disable;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in_ready  = !stall[STAGE];
        assign out_valid = valid_q;
        assign out_data  = data_q;
    end else begin : g_skid
        skid_state_e       state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              ready_q, ready_d;
        logic              valid_int;
        logic              accept;
        logic              consume;
        logic              unused_stall;

        assign unused_stall = ^stall;

        assign valid_int = (state_q != StEmpty);
        assign accept    = in_valid & ready_q;
        assign consume   = valid_int & out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (consume) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE_VAL;
                    end
                end
                StFull: begin
                    if (consume) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE_VAL;
                end
            endcase
            if (flush) begin
                state_d = StEmpty;
                main_d  = BUBBLE_VAL;
                skid_d  = BUBBLE_VAL;
            end
            // Registered ready: looks at the next state so FULL blocks upstream.
            ready_d = (state_d != StFull);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StEmpty;
                main_q  <= BUBBLE_VAL;
                skid_q  <= BUBBLE_VAL;
                ready_q <= Enable;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= ready_d;
            end
        end

        assign hold_inc   = valid_int & !out_ready;
        assign bubble_inc = out_ready & !valid_int;
        assign in_ready   = ready_q;
        assign out_valid  = valid_int;
        assign out_data   = main_q;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one stall-vector instance (4-bit counters) and one skid-buffer instance.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stall-vector instance
    logic          a_rst, a_flush, a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [5:0]    a_stall;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_hold, a_bubble;

    // Skid-buffer instance
    logic          b_rst, b_flush, b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [5:0]    b_stall;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_hold, b_bubble;

    pipe_stage_reg #(
        .DATA_W (DW),
        .STALL_W(6),
        .STAGE  (1),
        .MODE   (0),
        .CNT_W  (4)
    ) u_dut_stall (
        .clk       (clk),
        .rst       (a_rst),
        .stall     (a_stall),
        .flush     (a_flush),
        .cnt_clr   (a_clr),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .hold_cnt  (a_hold),
        .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(
        .DATA_W (DW),
        .STALL_W(6),
        .STAGE  (1),
        .MODE   (1),
        .CNT_W  (16)
    ) u_dut_skid (
        .clk       (clk),
        .rst       (b_rst),
        .stall     (b_stall),
        .flush     (b_flush),
        .cnt_clr   (b_clr),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .hold_cnt  (b_hold),
        .bubble_cnt(b_bubble)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        a_rst = 1'b1; a_stall = '0; a_flush = 1'b0; a_clr = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_stall = 6'b111111; b_flush = 1'b0; b_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        tick(2);
        a_rst = 1'b0;

        // ---------------- stall-vector mode ----------------
        check_eq("m0_rst_valid", a_out_valid, 0);
        check_eq("m0_rst_data", a_out_data, 0);
        check_eq("m0_rst_hold", a_hold, 0);
        check_eq("m0_rst_bubble", a_bubble, 0);
        check_eq("m0_rst_ready", a_in_ready, 1);

        a_in_data = 64'hBFC0_0000_3C01_0001; a_in_valid = 1'b1;
        tick(1);
        check_eq("m0_load_data", a_out_data, 64'hBFC0_0000_3C01_0001);
        check_eq("m0_load_valid", a_out_valid, 1);

        a_stall = 6'b000011; a_in_data = 64'h1111_2222_3333_4444;
        #1 check_eq("m0_ready_stalled", a_in_ready, 0);
        tick(1);
        check_eq("m0_bubble_data", a_out_data, 0);
        check_eq("m0_bubble_valid", a_out_valid, 0);
        check_eq("m0_bubble_cnt", a_bubble, 1);

        a_stall = 6'b000000; a_in_data = 64'hDEAD_BEEF_0000_0002;
        tick(1);
        a_stall = 6'b000111; a_in_data = 64'h5555_5555_5555_5555;
        tick(3);
        check_eq("m0_hold_data", a_out_data, 64'hDEAD_BEEF_0000_0002);
        check_eq("m0_hold_valid", a_out_valid, 1);
        check_eq("m0_hold_cnt", a_hold, 3);
        check_eq("m0_hold_bubble_unchanged", a_bubble, 1);

        a_stall = 6'b000000; a_in_valid = 1'b0; a_in_data = 64'h0123_4567_89AB_CDEF;
        tick(1);
        check_eq("m0_load_invalid_valid", a_out_valid, 0);
        check_eq("m0_load_invalid_data", a_out_data, 64'h0123_4567_89AB_CDEF);

        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 64'hFFFF_0000_FFFF_0000;
        tick(1);
        a_flush = 1'b0;
        check_eq("m0_flush_valid", a_out_valid, 0);
        check_eq("m0_flush_data", a_out_data, 0);
        check_eq("m0_flush_hold_kept", a_hold, 3);

        a_in_data = 64'hCAFE_F00D_0000_0006;
        tick(1);
        a_stall = 6'b000111;
        tick(20);
        check_eq("m0_hold_saturate", a_hold, 15);
        a_clr = 1'b1;
        tick(1);
        a_clr = 1'b0;
        check_eq("m0_clr_hold", a_hold, 0);
        check_eq("m0_clr_bubble", a_bubble, 0);
        tick(2);
        check_eq("m0_hold_after_clr", a_hold, 2);
        a_rst = 1'b1;
        tick(1);
        check_eq("m0_midrst_valid", a_out_valid, 0);
        check_eq("m0_midrst_data", a_out_data, 0);
        check_eq("m0_midrst_hold", a_hold, 0);
        a_rst = 1'b0; a_stall = '0;

        // ---------------- skid-buffer mode ----------------
        b_rst = 1'b0;
        check_eq("m1_rst_valid", b_out_valid, 0);
        check_eq("m1_rst_ready", b_in_ready, 1);
        check_eq("m1_rst_data", b_out_data, 0);

        b_in_valid = 1'b1; b_in_data = 64'hA;
        tick(1);
        check_eq("m1_a_valid", b_out_valid, 1);
        check_eq("m1_a_data", b_out_data, 64'hA);
        check_eq("m1_a_ready", b_in_ready, 1);
        b_in_data = 64'hB;
        tick(1);
        check_eq("m1_full_ready", b_in_ready, 0);
        check_eq("m1_full_data", b_out_data, 64'hA);
        b_in_data = 64'hC;
        tick(2);
        check_eq("m1_c_blocked_data", b_out_data, 64'hA);
        check_eq("m1_hold_cnt", b_hold, 3);

        b_out_ready = 1'b1;
        tick(1);
        check_eq("m1_out_b", b_out_data, 64'hB);
        check_eq("m1_ready_after_drain", b_in_ready, 1);
        tick(1);
        check_eq("m1_out_c", b_out_data, 64'hC);
        check_eq("m1_out_c_valid", b_out_valid, 1);
        b_in_valid = 1'b0;
        tick(1);
        check_eq("m1_drained_valid", b_out_valid, 0);
        tick(1);
        check_eq("m1_bubble_cnt", b_bubble, 1);
        check_eq("m1_hold_kept", b_hold, 3);

        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hD;
        tick(1);
        b_in_data = 64'hE;
        tick(1);
        b_in_valid = 1'b0;
        check_eq("m1_refill_ready", b_in_ready, 0);
        b_flush = 1'b1; b_out_ready = 1'b1;
        tick(1);
        b_flush = 1'b0; b_out_ready = 1'b0;
        check_eq("m1_flush_valid", b_out_valid, 0);
        check_eq("m1_flush_ready", b_in_ready, 1);
        check_eq("m1_flush_data", b_out_data, 0);
        tick(1);
        check_eq("m1_flush_no_resurface", b_out_valid, 0);
        check_eq("m1_flush_hold", b_hold, 4);

        b_in_valid = 1'b1; b_in_data = 64'hF; b_out_ready = 1'b1;
        tick(1);
        check_eq("m1_stream_f", b_out_data, 64'hF);
        b_in_data = 64'h10;
        tick(1);
        check_eq("m1_stream_g", b_out_data, 64'h10);
        check_eq("m1_stream_ready", b_in_ready, 1);
        check_eq("m1_stream_bubble", b_bubble, 2);

        b_out_ready = 1'b0; b_in_data = 64'h11;
        tick(1);
        b_rst = 1'b1; b_in_valid = 1'b0;
        tick(1);
        b_rst = 1'b0;
        check_eq("m1_midrst_valid", b_out_valid, 0);
        check_eq("m1_midrst_ready", b_in_ready, 1);
        check_eq("m1_midrst_hold", b_hold, 0);
        check_eq("m1_midrst_bubble", b_bubble, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
